// File: rtl/efi_spi_master.sv
// SPI mode-0 initiator: fixed-width MSB-first full-duplex words,
// programmable SCK rate, cs setup/hold timing and held-cs bursts.
module efi_spi_master #(
    parameter int WIDTH    = 16,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             hold_cs,
    input  logic             release_cs,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             cs
);

    localparam int TM0  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int TMAX = (TM0 > CS_HOLD) ? TM0 : CS_HOLD;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_GAP,
        S_HELD
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             hold_q, hold_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             cs_q, cs_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Next-state and next-output computation for the transfer sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        hold_d    = hold_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE, S_HELD: begin
                if (start) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = tx_data;
                    rx_d    = '0;
                    hold_d  = hold_cs;
                    sck_d   = 1'b0;
                    mosi_d  = tx_data[WIDTH-1];
                    cs_d    = 1'b0;
                end else if (state_q == S_HELD && release_cs) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_XFER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_XFER: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rx_d = {rx_q[WIDTH-2:0], miso};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d  = bit_q + BW'(1);
                        tx_d   = {tx_q[WIDTH-2:0], 1'b0};
                        mosi_d = tx_q[WIDTH-2];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                    if (hold_q) begin
                        state_d = S_HELD;
                        mosi_d  = 1'b0;
                    end else begin
                        state_d = S_GAP;
                        cs_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sck_d   = 1'b0;
            end
        endcase

        busy_d = !(state_d inside {S_IDLE, S_HELD});
    end

    // State and registered outputs; reset aborts any transfer at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            hold_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            hold_q    <= hold_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign cs      = cs_q;

endmodule

// File: tb/tb_efi_spi_master.sv
// Self-checking bench for efi_spi_master: random words against a
// responder/reference model, burst, release and parameter-corner cases.
module tb_efi_spi_master;

    localparam int W   = 16;
    localparam int CD  = 4;
    localparam int CSS = 2;
    localparam int CSH = 2;
    localparam int LAT = CSS + 2 * W * CD + CSH;
    localparam int LAT8 = 1 + 2 * 8 * 1 + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic         start = 1'b0;
    logic         hold_cs = 1'b0;
    logic         release_cs = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         busy, done, sck, mosi, cs, miso;
    logic [W-1:0] rx_data;

    efi_spi_master u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .tx_data(tx_data), .hold_cs(hold_cs), .release_cs(release_cs),
        .busy(busy), .done(done), .rx_data(rx_data), .sck(sck),
        .mosi(mosi), .miso(miso), .cs(cs)
    );

    logic       c_start = 1'b0;
    logic       c_hold = 1'b0;
    logic       c_rel = 1'b0;
    logic [7:0] c_tx = '0;
    logic [7:0] c_rx;
    logic       c_busy, c_done, c_sck, c_mosi, c_cs, c_miso;

    efi_spi_master #(
        .WIDTH(8), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)
    ) u_c (
        .clk(clk), .reset_n(reset_n), .start(c_start),
        .tx_data(c_tx), .hold_cs(c_hold), .release_cs(c_rel),
        .busy(c_busy), .done(c_done), .rx_data(c_rx), .sck(c_sck),
        .mosi(c_mosi), .miso(c_miso), .cs(c_cs)
    );

    // Responder model: presents the response word MSB first,
    // advancing after each sck rise; records mosi at each rise.
    logic [W-1:0] resp_w = '0;
    logic [W-1:0] mosi_hist = '0;
    int rise_total = 0;
    int frame_base = 0;
    int rn;
    assign rn = rise_total - frame_base;
    assign miso = (rn >= 0 && rn < W) ? resp_w[W-1-rn] : 1'b0;
    always @(posedge sck) begin
        rise_total <= rise_total + 1;
        mosi_hist  <= {mosi_hist[W-2:0], mosi};
    end

    logic [7:0] c_resp = '0;
    logic [7:0] c_hist = '0;
    int c_rise = 0;
    int c_base = 0;
    int c_rn;
    assign c_rn = c_rise - c_base;
    assign c_miso = (c_rn >= 0 && c_rn < 8) ? c_resp[7-c_rn] : 1'b0;
    always @(posedge c_sck) begin
        c_rise <= c_rise + 1;
        c_hist <= {c_hist[6:0], c_mosi};
    end

    // Per-cycle monitors: cs-high and done counts, sck run widths
    int cs_hi = 0, done_cnt = 0, werr = 0, hrun = 0, lrun = 0;
    bit lval = 1'b0;
    int c_werr = 0, c_hrun = 0, c_lrun = 0;
    bit c_lval = 1'b0;
    always @(posedge clk) begin
        #2;
        if (cs) cs_hi++;
        if (done) done_cnt++;
        if (sck) begin
            if (hrun == 0 && lval && lrun != CD) werr++;
            hrun++;
            lrun = 0;
            lval = 1'b0;
        end else begin
            if (hrun != 0) begin
                if (hrun != CD) werr++;
                lval = 1'b1;
            end
            hrun = 0;
            lrun++;
            if (lrun > 2 * CD) lval = 1'b0;
        end
        if (c_sck) begin
            if (c_hrun == 0 && c_lval && c_lrun != 1) c_werr++;
            c_hrun++;
            c_lrun = 0;
            c_lval = 1'b0;
        end else begin
            if (c_hrun != 0) begin
                if (c_hrun != 1) c_werr++;
                c_lval = 1'b1;
            end
            c_hrun = 0;
            c_lrun++;
            if (c_lrun > 2) c_lval = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic [W-1:0] tx, input logic [W-1:0] rsp,
                         input logic hc);
        start = 1'b1;
        tx_data = tx;
        hold_cs = hc;
        resp_w = rsp;
        frame_base = rise_total;
        @(negedge clk);
        start = 1'b0;
        tx_data = W'($urandom);
        hold_cs = ~hc;
    endtask

    task automatic wait_done(output int lat, input int poke);
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
            if (poke != 0 && lat == poke) begin
                start = 1'b1;
                tx_data = W'($urandom);
            end
            if (poke != 0 && lat == poke + 1) start = 1'b0;
        end
    endtask

    task automatic check_frame(input logic [W-1:0] tx,
                               input logic [W-1:0] rsp,
                               input int lat, input int w0);
        chk("latency", lat, LAT);
        chk("done_pulse", done, 1'b1);
        chk("rx_data", rx_data, rsp);
        chk("mosi_word", mosi_hist, tx);
        chk("sck_pulses", rise_total - frame_base, W);
        chk("sck_width", werr - w0, 0);
    endtask

    // Called at the negedge just after cs went high into the gap
    task automatic gap_check(input bit poke);
        chk("gap_cs", cs, 1'b1);
        chk("gap_busy", busy, 1'b1);
        if (poke) start = 1'b1;
        for (int i = 1; i <= CSH; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("gap_cs", cs, 1'b1);
            chk("gap_busy", busy, i < CSH);
        end
    endtask

    int lat, w0, c0, d0;
    logic [W-1:0] t, r;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cs", cs, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rx", rx_data, 0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(16'hFFFF, 16'hFFFF, 1'b0);
        repeat (40) @(negedge clk);
        chk("pre_abort_sck", sck, 1'b1);
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("abort_cs", cs, 1'b1);
        chk("abort_sck", sck, 1'b0);
        chk("abort_mosi", mosi, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rx", rx_data, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort_nodone", done_cnt - d0, 0);
        chk("abort_idle", busy, 1'b0);

        w0 = werr; c0 = cs_hi; d0 = done_cnt;
        issue(16'hA55A, 16'h3CC3, 1'b0);
        wait_done(lat, 10);
        check_frame(16'hA55A, 16'h3CC3, lat, w0);
        chk("cs_low_frame", cs_hi - c0, 1);
        gap_check(1'b1);
        repeat (4) @(negedge clk);
        chk("one_xfer", done_cnt - d0, 1);
        chk("idle_after", busy, 1'b0);

        for (int k = 0; k < 5; k++) begin
            t = W'($urandom);
            r = W'($urandom);
            w0 = werr; c0 = cs_hi;
            issue(t, r, 1'b0);
            wait_done(lat, 0);
            check_frame(t, r, lat, w0);
            chk("cs_low_frame", cs_hi - c0, 1);
            gap_check(1'b0);
            repeat (2) @(negedge clk);
        end

        t = W'($urandom);
        w0 = werr; c0 = cs_hi; d0 = done_cnt;
        issue(16'h0001, t, 1'b1);
        wait_done(lat, 0);
        check_frame(16'h0001, t, lat, w0);
        chk("held_busy", busy, 1'b0);
        chk("held_cs", cs, 1'b0);
        chk("held_mosi", mosi, 1'b0);
        r = W'($urandom);
        w0 = werr;
        issue(16'h0002, r, 1'b0);
        wait_done(lat, 0);
        check_frame(16'h0002, r, lat, w0);
        chk("burst_cs", cs_hi - c0, 1);
        chk("burst_dones", done_cnt - d0, 2);
        gap_check(1'b0);

        t = W'($urandom);
        r = W'($urandom);
        w0 = werr;
        issue(t, r, 1'b1);
        wait_done(lat, 0);
        check_frame(t, r, lat, w0);
        repeat (3) @(negedge clk);
        chk("held_stay_cs", cs, 1'b0);
        chk("held_stay_busy", busy, 1'b0);
        release_cs = 1'b1;
        @(negedge clk);
        release_cs = 1'b0;
        gap_check(1'b0);
        release_cs = 1'b1;
        @(negedge clk);
        release_cs = 1'b0;
        @(negedge clk);
        chk("idle_rel_busy", busy, 1'b0);
        chk("idle_rel_cs", cs, 1'b1);

        t = W'($urandom);
        r = W'($urandom);
        w0 = werr;
        issue(t, r, 1'b1);
        wait_done(lat, 0);
        check_frame(t, r, lat, w0);
        repeat (2) @(negedge clk);
        t = W'($urandom);
        r = W'($urandom);
        w0 = werr; c0 = cs_hi;
        release_cs = 1'b1;
        issue(t, r, 1'b0);
        release_cs = 1'b0;
        chk("sr_cs", cs, 1'b0);
        chk("sr_busy", busy, 1'b1);
        wait_done(lat, 0);
        check_frame(t, r, lat, w0);
        chk("sr_cs_low", cs_hi - c0, 1);
        gap_check(1'b0);

        for (int k = 0; k < 3; k++) begin
            logic [7:0] ct, cr;
            int cw0, cl;
            ct = (k == 0) ? 8'h81 : 8'($urandom);
            cr = 8'($urandom);
            cw0 = c_werr;
            c_start = 1'b1;
            c_tx = ct;
            c_resp = cr;
            c_base = c_rise;
            @(negedge clk);
            c_start = 1'b0;
            c_tx = ~ct;
            chk("c_cs_fall", c_cs, 1'b0);
            cl = 0;
            while (c_done !== 1'b1 && cl < 200) begin
                @(negedge clk);
                cl++;
            end
            chk("c_latency", cl, LAT8);
            chk("c_rx", c_rx, cr);
            chk("c_mosi_word", c_hist, ct);
            chk("c_pulses", c_rise - c_base, 8);
            chk("c_width", c_werr - cw0, 0);
            repeat (3) @(negedge clk);
            chk("c_idle", c_busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
